// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM address drive and the IF/ID pipeline register.
// The PC advances by 4 and can be stalled or redirected by a branch. Addresses at or past ROM_LIMIT fetch NOPs.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] ROM_LIMIT = 32'd364
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] rom_instruction,
  output logic [31:0] rom_address,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        out_of_range,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INSN_BYTES = 4;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] fetch_word;
  logic            in_range;

  // ROM is addressed directly by the PC so its word is usable this cycle
  assign rom_address = pc;
  assign in_range    = (pc < ROM_LIMIT);
  assign pc_plus4    = pc + XLEN'(INSN_BYTES);
  assign fetch_word  = in_range ? rom_instruction : '0;

  // Priority: reset, then branch redirect, then stall, then sequential fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      pc                <= RESET_PC;
      if_id_pc          <= '0;
      if_id_instruction <= '0;
      if_id_valid       <= 1'b0;
      out_of_range      <= 1'b0;
      fetch_count       <= '0;
    end else begin
      if (!in_range) begin
        out_of_range <= 1'b1;
      end
      if (branch_taken) begin
        pc                <= {branch_target[XLEN-1:2], 2'b00};
        if_id_pc          <= '0;
        if_id_instruction <= '0;
        if_id_valid       <= 1'b0;
      end else if (!freeze) begin
        pc                <= pc_plus4;
        if_id_pc          <= pc_plus4;
        if_id_instruction <= fetch_word;
        if_id_valid       <= in_range;
        if (in_range) begin
          fetch_count <= fetch_count + XLEN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: a driver pushes model predictions per cycle, a monitor pops and compares.
module tb_if_stage;

  localparam logic [31:0] LIMIT = 32'd364;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] rom_instruction;
  logic [31:0] rom_address;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        out_of_range;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ins;
    logic        v;
    logic        oor;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // reference state
  logic [31:0] m_pc, m_ifpc, m_ins, m_cnt;
  logic        m_v, m_oor;

  if_stage #(.RESET_PC(32'd0), .ROM_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .freeze(freeze), .branch_taken(branch_taken),
    .branch_target(branch_target), .rom_instruction(rom_instruction),
    .rom_address(rom_address), .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
    .if_id_valid(if_id_valid), .out_of_range(out_of_range), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h8001060A;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0001;
  endfunction

  assign rom_instruction = rom_word(rom_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // One cycle of stimulus; the model applies the spec rules and the prediction is queued
  task automatic step(input logic rst, input logic frz, input logic br, input logic [31:0] tgt);
    exp_t e;
    @(negedge clock);
    reset = rst; freeze = frz; branch_taken = br; branch_target = tgt;
    if (rst) begin
      m_pc = 32'd0; m_ifpc = 0; m_ins = 0; m_v = 0; m_oor = 0; m_cnt = 0;
    end else begin
      if (m_pc >= LIMIT) m_oor = 1'b1;
      if (br) begin
        m_pc = tgt & ~32'd3; m_ifpc = 0; m_ins = 0; m_v = 0;
      end else if (!frz) begin
        m_v    = (m_pc < LIMIT);
        m_ins  = m_v ? rom_word(m_pc) : 32'd0;
        m_cnt  = m_cnt + (m_v ? 32'd1 : 32'd0);
        m_pc   = m_pc + 32'd4;
        m_ifpc = m_pc;
      end
    end
    e = '{pc: m_pc, ifpc: m_ifpc, ins: m_ins, v: m_v, oor: m_oor, cnt: m_cnt};
    exp_q.push_back(e);
  endtask

  // Let the last queued prediction retire so direct checks see a settled state
  task automatic settle();
    @(posedge clock);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: outputs are presented every cycle, compared just after the edge
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rom_address", rom_address, e.pc);
      chk("if_id_pc", if_id_pc, e.ifpc);
      chk("if_id_instruction", if_id_instruction, e.ins);
      chk("if_id_valid", 32'(if_id_valid), 32'(e.v));
      chk("out_of_range", 32'(out_of_range), 32'(e.oor));
      chk("fetch_count", fetch_count, e.cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [31:0] t;
    // reset for two cycles, then first fetch from address 0
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    settle();
    chk("boot_ins", if_id_instruction, 32'h8001060A);
    chk("boot_ifpc", if_id_pc, 32'd4);
    chk("boot_valid", 32'(if_id_valid), 32'd1);
    chk("boot_addr", rom_address, 32'd4);
    chk("boot_count", fetch_count, 32'd1);

    // stall at PC=12 for three cycles, then resume
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    settle();
    chk("stall_pc", rom_address, 32'd12);
    chk("stall_count", fetch_count, 32'd3);
    step(0, 0, 0, 0);
    settle();
    chk("resume_pc", rom_address, 32'd16);

    // branch wins over freeze, then one fetch from the target
    step(0, 1, 1, 32'h58);
    settle();
    chk("br_pc", rom_address, 32'h58);
    chk("br_valid", 32'(if_id_valid), 32'd0);
    step(0, 0, 0, 0);
    settle();
    chk("br_next_ifpc", if_id_pc, 32'h5C);

    // unaligned target loses its low bits
    step(0, 0, 1, 32'h5B);
    settle();
    chk("align_pc", rom_address, 32'h58);

    // free run to the ROM limit and beyond
    step(1, 0, 0, 0);
    for (int i = 0; i < 95; i++) step(0, 0, 0, 0);
    settle();
    chk("limit_count", fetch_count, 32'd91);
    chk("limit_oor", 32'(out_of_range), 32'd1);
    chk("limit_valid", 32'(if_id_valid), 32'd0);
    chk("limit_ins", if_id_instruction, 32'd0);

    // reset while stalled at PC=40
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h100);
    settle();
    chk("rst_stall_pc", rom_address, 32'd0);
    chk("rst_stall_count", fetch_count, 32'd0);
    chk("rst_stall_oor", 32'(out_of_range), 32'd0);

    // 32-bit PC wrap
    step(0, 0, 1, 32'hFFFFFFFE);
    step(0, 0, 0, 0);
    settle();
    chk("wrap_pc", rom_address, 32'd0);
    chk("wrap_oor", 32'(out_of_range), 32'd1);

    // randomized traffic
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      t = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 420));
      step(r < 1, r >= 1 && r < 22, (r >= 15 && r < 23), t);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
